// File: rtl/inst_fetch_pkg.sv
// Shared widths, reset PC and FSM state encoding for the instruction fetch unit.
package inst_fetch_pkg;

    localparam int          PC_BUS       = 32;
    localparam int          INST_BUS     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'b00,
        FETCH_WAIT = 2'b01,
        FETCH_DROP = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_hold.sv
// Two-slot holding register between instruction memory and the IF->ID buffer.
// Compacts the pair when the fetch PC points at the upper word and derives npc.
module inst_fetch_hold
    import inst_fetch_pkg::*;
#(
    parameter int PC_W   = PC_BUS,
    parameter int INST_W = INST_BUS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                load,
    input  logic                send,
    input  logic [PC_W-1:0]     fpc,
    input  logic [2*INST_W-1:0] rdata,
    output logic                hold_v,
    output logic                two_v,
    output logic [INST_W-1:0]   inst1,
    output logic [PC_W-1:0]     pc1,
    output logic [PC_W-1:0]     npc1,
    output logic [INST_W-1:0]   inst2,
    output logic [PC_W-1:0]     pc2,
    output logic [PC_W-1:0]     npc2
);

    localparam logic [PC_W-1:0] ALIGN8  = {{(PC_W-3){1'b1}}, 3'b000};
    localparam logic [PC_W-1:0] PC_STEP = {{(PC_W-3){1'b0}}, 3'b100};

    logic                v_r;
    logic                two_r;
    logic [INST_W-1:0]   inst1_r;
    logic [INST_W-1:0]   inst2_r;
    logic [PC_W-1:0]     pc1_r;
    logic [PC_W-1:0]     pc2_r;
    logic [PC_W-1:0]     base_s;

    assign base_s = fpc & ALIGN8;

    // Capture a response, or drop the pair on redirect / once it has been sent.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_r     <= 1'b0;
            two_r   <= 1'b0;
            inst1_r <= {INST_W{1'b0}};
            inst2_r <= {INST_W{1'b0}};
            pc1_r   <= {PC_W{1'b0}};
            pc2_r   <= {PC_W{1'b0}};
        end else if (flush) begin
            v_r   <= 1'b0;
            two_r <= 1'b0;
        end else if (load) begin
            v_r <= 1'b1;
            // An upper-word fetch PC means the lower word precedes the target.
            if (fpc[2]) begin
                inst1_r <= rdata[2*INST_W-1:INST_W];
                pc1_r   <= base_s + PC_STEP;
                inst2_r <= {INST_W{1'b0}};
                pc2_r   <= {PC_W{1'b0}};
                two_r   <= 1'b0;
            end else begin
                inst1_r <= rdata[INST_W-1:0];
                pc1_r   <= base_s;
                inst2_r <= rdata[2*INST_W-1:INST_W];
                pc2_r   <= base_s + PC_STEP;
                two_r   <= 1'b1;
            end
        end else if (send) begin
            v_r   <= 1'b0;
            two_r <= 1'b0;
        end
    end

    assign hold_v = v_r;
    assign two_v  = two_r;
    assign inst1  = inst1_r;
    assign pc1    = pc1_r;
    assign npc1   = pc1_r + PC_STEP;
    assign inst2  = inst2_r;
    assign pc2    = pc2_r;
    assign npc2   = pc2_r + PC_STEP;

endmodule

// File: rtl/inst_fetch.sv
// Fetch-side producer for the IF->ID buffer: owns the PC, issues aligned 64-bit
// fetches with at most one outstanding, and restarts on EX redirects.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int              PC_W     = PC_BUS,
    parameter int              INST_W   = INST_BUS,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stop,
    input  logic                instbuf_full,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_pc,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [2*INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0]   out1_inst,
    output logic [PC_W-1:0]     out1_pc,
    output logic [PC_W-1:0]     out1_npc,
    output logic                send_flag1,
    output logic [INST_W-1:0]   out2_inst,
    output logic [PC_W-1:0]     out2_pc,
    output logic [PC_W-1:0]     out2_npc,
    output logic                send_flag2
);

    localparam logic [PC_W-1:0] ALIGN8     = {{(PC_W-3){1'b1}}, 3'b000};
    localparam logic [PC_W-1:0] ALIGN4     = {{(PC_W-2){1'b1}}, 2'b00};
    localparam logic [PC_W-1:0] FETCH_STEP = {{(PC_W-4){1'b0}}, 4'b1000};

    fetch_state_e      state_r;
    fetch_state_e      state_next_s;
    logic [PC_W-1:0]   pc_r;
    logic [PC_W-1:0]   pc_next_s;
    logic [PC_W-1:0]   fpc_r;
    logic [PC_W-1:0]   fpc_next_s;
    logic              load_s;
    logic              hold_v_s;
    logic              two_v_s;
    logic              send_now_s;
    logic              req_s;
    logic              gnt_s;
    logic [INST_W-1:0] inst1_s;
    logic [INST_W-1:0] inst2_s;
    logic [PC_W-1:0]   pc1_s;
    logic [PC_W-1:0]   npc1_s;
    logic [PC_W-1:0]   pc2_s;
    logic [PC_W-1:0]   npc2_s;

    // A new request may overlap the cycle in which the current pair drains.
    assign send_now_s = hold_v_s && !instbuf_full && !stop && !redirect_valid;
    assign req_s      = (state_r == FETCH_REQ) && (!hold_v_s || send_now_s);
    assign gnt_s      = req_s && imem_gnt;

    // Next-state, PC and hold-load decode; redirect overrides the PC in every state.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        fpc_next_s   = fpc_r;
        load_s       = 1'b0;
        case (state_r)
            FETCH_REQ: begin
                if (gnt_s) begin
                    fpc_next_s   = pc_r;
                    pc_next_s    = (pc_r & ALIGN8) + FETCH_STEP;
                    state_next_s = redirect_valid ? FETCH_DROP : FETCH_WAIT;
                end else begin
                    state_next_s = FETCH_REQ;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid) begin
                    load_s       = !redirect_valid;
                    state_next_s = FETCH_REQ;
                end else if (redirect_valid) begin
                    state_next_s = FETCH_DROP;
                end else begin
                    state_next_s = FETCH_WAIT;
                end
            end
            FETCH_DROP: begin
                if (imem_rvalid) begin
                    state_next_s = FETCH_REQ;
                end else begin
                    state_next_s = FETCH_DROP;
                end
            end
            default: begin
                state_next_s = FETCH_REQ;
            end
        endcase
        if (redirect_valid) begin
            pc_next_s = redirect_pc & ALIGN4;
        end else begin
            pc_next_s = pc_next_s;
        end
    end

    // FSM, PC and fetch-PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= FETCH_REQ;
            pc_r    <= RESET_PC;
            fpc_r   <= RESET_PC;
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
            fpc_r   <= fpc_next_s;
        end
    end

    inst_fetch_hold #(
        .PC_W   (PC_W),
        .INST_W (INST_W)
    ) u_hold (
        .clk    (clk),
        .rst    (rst),
        .flush  (redirect_valid),
        .load   (load_s),
        .send   (send_now_s),
        .fpc    (fpc_r),
        .rdata  (imem_rdata),
        .hold_v (hold_v_s),
        .two_v  (two_v_s),
        .inst1  (inst1_s),
        .pc1    (pc1_s),
        .npc1   (npc1_s),
        .inst2  (inst2_s),
        .pc2    (pc2_s),
        .npc2   (npc2_s)
    );

    // Outputs read as idle while reset is held, whatever the registers contain.
    assign imem_req   = req_s && !rst;
    assign imem_addr  = rst ? (RESET_PC & ALIGN8) : (pc_r & ALIGN8);
    assign send_flag1 = send_now_s && !rst;
    assign send_flag2 = send_now_s && two_v_s && !rst;
    assign out1_inst  = rst ? {INST_W{1'b0}} : inst1_s;
    assign out1_pc    = rst ? {PC_W{1'b0}}   : pc1_s;
    assign out1_npc   = rst ? {PC_W{1'b0}}   : npc1_s;
    assign out2_inst  = rst ? {INST_W{1'b0}} : inst2_s;
    assign out2_pc    = rst ? {PC_W{1'b0}}   : pc2_s;
    assign out2_npc   = rst ? {PC_W{1'b0}}   : npc2_s;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a latency-programmable memory responder plus a
// linear cycle-by-cycle script with hand-computed expectations.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stop;
    logic        instbuf_full;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [63:0] imem_rdata  = 64'd0;
    logic [31:0] out1_inst, out1_pc, out1_npc, out2_inst, out2_pc, out2_npc;
    logic        send_flag1, send_flag2;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          lat     = 1;
    int          cnt     = 0;
    logic        pend    = 1'b0;
    logic [31:0] paddr   = 32'd0;

    localparam logic [31:0] IKEY = 32'hA500_0000;

    inst_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .stop           (stop),
        .instbuf_full   (instbuf_full),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out1_inst      (out1_inst),
        .out1_pc        (out1_pc),
        .out1_npc       (out1_npc),
        .send_flag1     (send_flag1),
        .out2_inst      (out2_inst),
        .out2_pc        (out2_pc),
        .out2_npc       (out2_npc),
        .send_flag2     (send_flag2)
    );

    always #5 clk = ~clk;

    // Memory accepts a granted request on the clock edge.
    always @(posedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else if (imem_req && imem_gnt) begin
            pend  = 1'b1;
            cnt   = lat;
            paddr = imem_addr;
        end
    end

    // Memory returns {inst@addr+4, inst@addr} lat cycles after the grant.
    always @(negedge clk) begin
        imem_rvalid = 1'b0;
        if (pend) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = {(paddr + 32'd4) ^ IKEY, paddr ^ IKEY};
                pend        = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; stop = 1'b0; instbuf_full = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'd0; imem_gnt = 1'b1;

        // ---- reset
        @(negedge clk); @(negedge clk); #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_f1", {31'd0, send_flag1}, 32'd0);
        chk("rst_f2", {31'd0, send_flag2}, 32'd0);
        chk("rst_inst1", out1_inst, 32'h0);
        rst = 1'b0; #1;
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        chk("post_rst_f1", {31'd0, send_flag1}, 32'd0);

        // ---- 1: streaming, k=1
        @(negedge clk); #1;
        chk("t1_wait_req", {31'd0, imem_req}, 32'd0);
        chk("t1_wait_f1", {31'd0, send_flag1}, 32'd0);
        @(negedge clk); #1;
        chk("t1_f1", {31'd0, send_flag1}, 32'd1);
        chk("t1_f2", {31'd0, send_flag2}, 32'd1);
        chk("t1_i1", out1_inst, 32'hA500_0000);
        chk("t1_pc1", out1_pc, 32'h0);
        chk("t1_npc1", out1_npc, 32'h4);
        chk("t1_i2", out2_inst, 32'hA500_0004);
        chk("t1_pc2", out2_pc, 32'h4);
        chk("t1_npc2", out2_npc, 32'h8);
        chk("t1_addr8", imem_addr, 32'h8);
        chk("t1_req8", {31'd0, imem_req}, 32'd1);
        @(negedge clk); #1;
        chk("t1_wait2_f1", {31'd0, send_flag1}, 32'd0);

        // ---- 2: buffer full for 5 cycles on the (8,C) pair
        @(negedge clk); instbuf_full = 1'b1; #1;
        chk("t2_f1", {31'd0, send_flag1}, 32'd0);
        chk("t2_f2", {31'd0, send_flag2}, 32'd0);
        chk("t2_req", {31'd0, imem_req}, 32'd0);
        chk("t2_pc1", out1_pc, 32'h8);
        chk("t2_i1", out1_inst, 32'hA500_0008);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("t2_hold_f1", {31'd0, send_flag1}, 32'd0);
            chk("t2_hold_req", {31'd0, imem_req}, 32'd0);
            chk("t2_hold_npc2", out2_npc, 32'h10);
        end
        @(negedge clk); instbuf_full = 1'b0; #1;
        chk("t2_rel_f1", {31'd0, send_flag1}, 32'd1);
        chk("t2_rel_f2", {31'd0, send_flag2}, 32'd1);
        chk("t2_rel_pc1", out1_pc, 32'h8);
        chk("t2_rel_npc1", out1_npc, 32'hC);
        chk("t2_rel_pc2", out2_pc, 32'hC);
        chk("t2_rel_addr", imem_addr, 32'h10);
        @(negedge clk); #1;
        chk("t2_once_f1", {31'd0, send_flag1}, 32'd0);
        @(negedge clk); #1;
        chk("t2_next_f1", {31'd0, send_flag1}, 32'd1);
        chk("t2_next_pc1", out1_pc, 32'h10);
        chk("t2_next_pc2", out2_pc, 32'h14);
        chk("t2_next_addr", imem_addr, 32'h18);

        // ---- 4: redirect coincident with rvalid of the 0x18 fetch
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
        chk("t4_f1", {31'd0, send_flag1}, 32'd0);
        chk("t4_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk); redirect_valid = 1'b0; lat = 2; #1;
        chk("t4_req_next", {31'd0, imem_req}, 32'd1);
        chk("t4_addr", imem_addr, 32'h200);
        chk("t4_f1_next", {31'd0, send_flag1}, 32'd0);

        // ---- 3: redirect to 0x104 while WAIT, no rvalid that cycle
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h104; #1;
        chk("t3_f1", {31'd0, send_flag1}, 32'd0);
        @(negedge clk); redirect_valid = 1'b0; #1;
        chk("t3_drop_req", {31'd0, imem_req}, 32'd0);
        chk("t3_drop_f1", {31'd0, send_flag1}, 32'd0);
        @(negedge clk); lat = 1; #1;
        chk("t3_req", {31'd0, imem_req}, 32'd1);
        chk("t3_addr", imem_addr, 32'h100);
        chk("t3_req_f1", {31'd0, send_flag1}, 32'd0);
        @(negedge clk); #1;
        chk("t3_wait_f1", {31'd0, send_flag1}, 32'd0);
        @(negedge clk); #1;
        chk("t3_f1_send", {31'd0, send_flag1}, 32'd1);
        chk("t3_f2_send", {31'd0, send_flag2}, 32'd0);
        chk("t3_i1", out1_inst, 32'hA500_0104);
        chk("t3_pc1", out1_pc, 32'h104);
        chk("t3_npc1", out1_npc, 32'h108);
        chk("t3_addr_next", imem_addr, 32'h108);
        @(negedge clk); #1;
        chk("t3_wait2_f1", {31'd0, send_flag1}, 32'd0);

        // ---- 5: stop for 3 cycles, then k=3 fetch
        @(negedge clk); stop = 1'b1; lat = 3; #1;
        chk("t5_f1", {31'd0, send_flag1}, 32'd0);
        chk("t5_f2", {31'd0, send_flag2}, 32'd0);
        chk("t5_req", {31'd0, imem_req}, 32'd0);
        chk("t5_pc1", out1_pc, 32'h108);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk("t5_stop_f1", {31'd0, send_flag1}, 32'd0);
            chk("t5_stop_req", {31'd0, imem_req}, 32'd0);
        end
        @(negedge clk); stop = 1'b0; #1;
        chk("t5_go_f1", {31'd0, send_flag1}, 32'd1);
        chk("t5_go_f2", {31'd0, send_flag2}, 32'd1);
        chk("t5_go_pc1", out1_pc, 32'h108);
        chk("t5_go_pc2", out2_pc, 32'h10C);
        chk("t5_go_addr", imem_addr, 32'h110);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("t5_wait_f1", {31'd0, send_flag1}, 32'd0);
            chk("t5_wait_req", {31'd0, imem_req}, 32'd0);
        end
        @(negedge clk); #1;
        chk("t5_f1_send", {31'd0, send_flag1}, 32'd1);
        chk("t5_pc1_send", out1_pc, 32'h110);
        chk("t5_pc2_send", out2_pc, 32'h114);
        chk("t5_i1_send", out1_inst, 32'hA500_0110);
        chk("t5_addr_next", imem_addr, 32'h118);

        // ---- 6: reset while in DROP
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h300; #1;
        chk("t6_redir_f1", {31'd0, send_flag1}, 32'd0);
        @(negedge clk); redirect_valid = 1'b0; rst = 1'b1; #1;
        chk("t6_rst_req", {31'd0, imem_req}, 32'd0);
        chk("t6_rst_addr", imem_addr, 32'h0);
        chk("t6_rst_i1", out1_inst, 32'h0);
        @(negedge clk); rst = 1'b0; lat = 1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFA; #1;
        chk("t6_req", {31'd0, imem_req}, 32'd1);
        chk("t6_addr", imem_addr, 32'h0);
        chk("t6_f1", {31'd0, send_flag1}, 32'd0);
        chk("t6_f2", {31'd0, send_flag2}, 32'd0);

        // ---- redirect coincident with grant, then PC wrap
        @(negedge clk); redirect_valid = 1'b0; #1;
        chk("wr_drop_req", {31'd0, imem_req}, 32'd0);
        chk("wr_drop_f1", {31'd0, send_flag1}, 32'd0);
        @(negedge clk); #1;
        chk("wr_req", {31'd0, imem_req}, 32'd1);
        chk("wr_addr", imem_addr, 32'hFFFF_FFF8);
        @(negedge clk); #1;
        chk("wr_wait_f1", {31'd0, send_flag1}, 32'd0);
        @(negedge clk); #1;
        chk("wr_f1", {31'd0, send_flag1}, 32'd1);
        chk("wr_f2", {31'd0, send_flag2}, 32'd1);
        chk("wr_i1", out1_inst, 32'h5AFF_FFF8);
        chk("wr_pc1", out1_pc, 32'hFFFF_FFF8);
        chk("wr_npc1", out1_npc, 32'hFFFF_FFFC);
        chk("wr_pc2", out2_pc, 32'hFFFF_FFFC);
        chk("wr_npc2", out2_npc, 32'h0);
        chk("wr_addr_wrap", imem_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
